piso_shift_reg: RTL and testbench
=================================

// Module: piso_shift_reg
// PURPOSE
//   Parametrised parallel-in serial-out shift register with ready/valid on both sides.
//   Accepts a WIDTH-bit word, then emits it one bit per accepted transfer.
//   Bit order is selectable; an optional parity bit can follow each word.
//   Sits between the parallel datapath and the serial link / bit-serial consumers.
// PARAMETERS
//   WIDTH      8   data word width in bits, >= 1
//   MSB_FIRST  1   1: din[WIDTH-1] shifted out first; 0: din[0] first
// PORTS
//   clk         in   1      clock, all state updates on rising edge
//   reset       in   1      asynchronous, active-low reset (0 = reset asserted)
//   din         in   WIDTH  parallel word, sampled when load_valid && load_ready
//   load_valid  in   1      parallel word available
//   load_ready  out  1      block can accept a word this cycle
//   s_ready     in   1      downstream accepts the current serial bit
//   s_out       out  1      current serial bit
//   s_valid     out  1      s_out is valid
//   s_last      out  1      current bit is the final bit of the frame
//   busy        out  1      a frame is in progress (state != IDLE)
// BEHAVIOUR
//   - Reset (reset==0, async): state=IDLE, shift reg=0, counter=0.
//     Outputs: s_out=0, s_valid=0, s_last=0, busy=0, load_ready=1.
//   - FSM states: IDLE, SHIFT, PARITY (PARITY exists only with PISO_PARITY_EN).
//   - IDLE: load_ready=1, s_valid=0.
//     On load_valid: capture din, clear bit counter, go SHIFT.
//   - Latency: first bit on s_out with s_valid=1 in the cycle after load acceptance.
//   - SHIFT:
//     - s_valid=1; s_out = shreg[WIDTH-1] (MSB_FIRST=1) or shreg[0] (MSB_FIRST=0).
//     - Beat accepted when s_valid && s_ready: shift by one toward the output end
//       (zero-fill), counter+1.
//     - s_ready=0 stalls: s_out, s_last and the counter hold exactly.
//   - Counter is $clog2(WIDTH+1) bits and counts 0..WIDTH-1; it never wraps past
//     WIDTH-1 within a frame.
//   - s_last=1 when counter==WIDTH-1 in SHIFT (no parity), or in PARITY.
//   - load_ready is combinational: 1 in IDLE, or when the final beat is being
//     accepted this cycle (s_valid && s_ready && s_last). 0 otherwise.
//   - Final beat accepted:
//     - with load_valid=1 in the same cycle: load the new word and stay in SHIFT
//       (back-to-back frames, zero bubble).
//     - otherwise go IDLE.
//   - load_valid while load_ready=0: ignored; din is not sampled and the
//     upstream must hold.
//   - WIDTH=1: every frame is one beat; s_last=1 on every data beat (no parity).
//   - Reset mid-frame: frame aborted, remaining bits discarded, outputs return
//     to reset values immediately.
//   - busy=1 in SHIFT and PARITY.
// CONFIGURATION
//   PISO_PARITY_EN defined:
//     - Word parity (XOR of din) is captured at load.
//     - After bit WIDTH-1 is accepted, go to PARITY: s_out = even-parity bit,
//       s_valid=1, s_last=1.
//     - Acceptance of the parity beat ends the frame (same back-to-back rule).
//     - Frame = WIDTH+1 beats.
//   PISO_PARITY_EN undefined:
//     - No PARITY state, no parity storage.
//     - Frame = WIDTH beats; s_last on data bit WIDTH-1.
// TESTING
//   1. WIDTH=8, MSB_FIRST=1, din=8'hA5 loaded, s_ready=1
//      -> s_out 1,0,1,0,0,1,0,1 on consecutive cycles; s_last only on 8th;
//         then IDLE, busy=0.
//   2. MSB_FIRST=0, din=8'hA5 -> s_out 1,0,1,0,0,1,0,1 (LSB first);
//      din=8'h01 -> 1 then seven 0s.
//   3. Stall: s_ready=0 for 3 cycles at bit 4 -> s_out/s_last held, 8 beats
//      still total, no bit lost or duplicated.
//   4. Back-to-back: 8'hFF then 8'h00 with load_valid=1 on the last beat
//      -> 16 contiguous beats, s_valid never drops, two s_last pulses.
//   5. Reset (reset=0) asserted after 3 beats of 8'hC3 -> s_valid=0,
//      load_ready=1 immediately; a next load of 8'h81 emits cleanly.
//   6. PISO_PARITY_EN, din=8'h07 -> 8 data beats then parity beat 1 with s_last;
//      din=8'h03 -> parity beat 0.

Source files
------------

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register with ready/valid on both sides.
// Define PISO_PARITY_EN to append an even-parity beat after each word.
module piso_shift_reg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             s_ready,
  output logic             s_out,
  output logic             s_valid,
  output logic             s_last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
  logic parity_reg;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state_reg;
  logic [WIDTH-1:0] shreg_reg;
  logic [WIDTH-1:0] shreg_shifted;
  logic [CW-1:0]    cnt_reg;
  logic             data_bit;
  logic             beat;
  logic             load_fire;

  // One-position move toward the output end, zero-filling the far end.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (MSB_FIRST) begin : g_msb
        if (gi == 0) begin : g_fill
          assign shreg_shifted[gi] = 1'b0;
        end else begin : g_move
          assign shreg_shifted[gi] = shreg_reg[gi-1];
        end
      end else begin : g_lsb
        if (gi == WIDTH - 1) begin : g_fill
          assign shreg_shifted[gi] = 1'b0;
        end else begin : g_move
          assign shreg_shifted[gi] = shreg_reg[gi+1];
        end
      end
    end
  endgenerate

  assign data_bit   = MSB_FIRST ? shreg_reg[WIDTH-1] : shreg_reg[0];
  assign s_valid    = (state_reg != IDLE);
  assign busy       = (state_reg != IDLE);
  assign beat       = s_valid && s_ready;
  // Ready again while the final beat leaves, giving zero-bubble back-to-back frames.
  assign load_ready = (state_reg == IDLE) || (beat && s_last);
  assign load_fire  = load_valid && load_ready;

  always_comb begin
    s_out  = 1'b0;
    s_last = 1'b0;
    case (state_reg)
      SHIFT: begin
        s_out = data_bit;
`ifdef PISO_PARITY_EN
        s_last = 1'b0;
`else
        s_last = (cnt_reg == LAST_IDX);
`endif
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        s_out  = parity_reg;
        s_last = 1'b1;
      end
`endif
      default: begin
        s_out  = 1'b0;
        s_last = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      shreg_reg <= '0;
      cnt_reg   <= '0;
`ifdef PISO_PARITY_EN
      parity_reg <= 1'b0;
`endif
    end else if (load_fire) begin
      state_reg <= SHIFT;
      shreg_reg <= din;
      cnt_reg   <= '0;
`ifdef PISO_PARITY_EN
      parity_reg <= ^din;
`endif
    end else if (beat) begin
      case (state_reg)
        SHIFT: begin
          shreg_reg <= shreg_shifted;
          if (cnt_reg == LAST_IDX) begin
`ifdef PISO_PARITY_EN
            state_reg <= PARITY;
`else
            state_reg <= IDLE;
            cnt_reg   <= '0;
`endif
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
`ifdef PISO_PARITY_EN
        PARITY: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
        end
`endif
        default: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_shift_reg.sv
// Self-checking bench for piso_shift_reg: MSB-first, LSB-first and WIDTH=1 instances.
// Honours PISO_PARITY_EN when defined for the whole build.
module tb_piso_shift_reg;

`ifdef PISO_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int FRAME = PAR ? 9 : 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [7:0] din;
  logic       load_valid, s_ready;
  logic       m_lr, m_out, m_val, m_last, m_busy;
  logic       l_lr, l_out, l_val, l_last, l_busy;
  logic       w_din, w_lv, w_sr;
  logic       w_lr, w_out, w_val, w_last, w_busy;

  piso_shift_reg #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .din(din), .load_valid(load_valid), .load_ready(m_lr),
    .s_ready(s_ready), .s_out(m_out), .s_valid(m_val), .s_last(m_last), .busy(m_busy));

  piso_shift_reg #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .din(din), .load_valid(load_valid), .load_ready(l_lr),
    .s_ready(s_ready), .s_out(l_out), .s_valid(l_val), .s_last(l_last), .busy(l_busy));

  piso_shift_reg #(.WIDTH(1), .MSB_FIRST(1'b1)) u_w1 (
    .clk(clk), .reset(reset), .din(w_din), .load_valid(w_lv), .load_ready(w_lr),
    .s_ready(w_sr), .s_out(w_out), .s_valid(w_val), .s_last(w_last), .busy(w_busy));

  int checks = 0;
  int errors = 0;

  // Scoreboard entries are {bit, last}; the word fields hold bits in emission order (bit 7 first).
  logic [1:0] q_m[$];
  logic [1:0] q_l[$];
  logic [1:0] em, el;
  logic [7:0] exp_m, exp_l;
  logic       exp_par;

  typedef struct {
    logic [7:0] din;
    logic [7:0] seq_m;
    logic [7:0] seq_l;
    logic       par;
    bit         stall;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      q_m.delete();
      q_l.delete();
    end else begin
      if (m_val && s_ready) begin
        if (q_m.size() == 0) chk("msb unexpected beat", 1, 0);
        else begin
          em = q_m.pop_front();
          chk("msb s_out", 32'(m_out), 32'(em[1]));
          chk("msb s_last", 32'(m_last), 32'(em[0]));
        end
      end
      if (l_val && s_ready) begin
        if (q_l.size() == 0) chk("lsb unexpected beat", 1, 0);
        else begin
          el = q_l.pop_front();
          chk("lsb s_out", 32'(l_out), 32'(el[1]));
          chk("lsb s_last", 32'(l_last), 32'(el[0]));
        end
      end
      if (load_valid && m_lr) begin
        for (int i = 7; i >= 0; i--) q_m.push_back({exp_m[i], (i == 0) && !PAR});
        if (PAR) q_m.push_back({exp_par, 1'b1});
      end
      if (load_valid && l_lr) begin
        for (int i = 7; i >= 0; i--) q_l.push_back({exp_l[i], (i == 0) && !PAR});
        if (PAR) q_l.push_back({exp_par, 1'b1});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [7:0] d, input logic [7:0] sm, input logic [7:0] sl,
                           input logic p);
    bit acc = 1'b0;
    din = d; exp_m = sm; exp_l = sl; exp_par = p; load_valid = 1'b1;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      if (m_lr) acc = 1'b1;
    end
    cyc();
    load_valid = 1'b0;
    if (!acc) chk("load accept timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit idle = 1'b0;
    for (int k = 0; k < 100 && !idle; k++) begin
      @(negedge clk);
      if (!m_busy && !l_busy) idle = 1'b1;
    end
    if (!idle) chk("idle timeout", 0, 1);
    chk("idle load_ready", 32'(m_lr), 1);
    chk("idle s_valid", 32'(m_val), 0);
    chk("msb queue drained", 32'(q_m.size()), 0);
    chk("lsb queue drained", 32'(q_l.size()), 0);
  endtask

  initial begin
    logic hv_m, hl_m, hv_l;
    int   run, lasts;
    bit   done;

    tbl[0] = '{8'hA5, 8'hA5, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{8'h01, 8'h01, 8'h80, 1'b1, 1'b0};
    tbl[2] = '{8'hC3, 8'hC3, 8'hC3, 1'b0, 1'b1};
    tbl[3] = '{8'h12, 8'h12, 8'h48, 1'b0, 1'b0};
    tbl[4] = '{8'h07, 8'h07, 8'hE0, 1'b1, 1'b0};
    tbl[5] = '{8'h03, 8'h03, 8'hC0, 1'b0, 1'b1};
    tbl[6] = '{8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0};

    reset = 1'b0; din = '0; load_valid = 1'b0; s_ready = 1'b1;
    exp_m = '0; exp_l = '0; exp_par = 1'b0;
    w_din = 1'b0; w_lv = 1'b0; w_sr = 1'b1;
    cyc(); cyc();
    chk("reset s_out", 32'(m_out), 0);
    chk("reset s_valid", 32'(m_val), 0);
    chk("reset s_last", 32'(m_last), 0);
    chk("reset busy", 32'(m_busy), 0);
    chk("reset load_ready", 32'(m_lr), 1);
    chk("reset lsb s_valid", 32'(l_val), 0);
    reset = 1'b1;
    cyc();

    for (int i = 0; i < 7; i++) begin
      load_word(tbl[i].din, tbl[i].seq_m, tbl[i].seq_l, tbl[i].par);
      chk("first beat latency", 32'(m_val), 1);
      chk("busy in frame", 32'(m_busy), 1);
      chk("load_ready mid frame", 32'(m_lr), 0);
      if (tbl[i].stall) begin
        for (int k = 0; k < 4; k++) cyc();
        s_ready = 1'b0;
        hv_m = m_out; hl_m = m_last; hv_l = l_out;
        for (int k = 0; k < 3; k++) begin
          cyc();
          chk("stall msb s_out hold", 32'(m_out), 32'(hv_m));
          chk("stall msb s_last hold", 32'(m_last), 32'(hl_m));
          chk("stall lsb s_out hold", 32'(l_out), 32'(hv_l));
          chk("stall s_valid hold", 32'(m_val), 1);
        end
        s_ready = 1'b1;
      end
      wait_idle();
      cyc();
    end

    // Back-to-back: second word held on load_valid until the final beat of the first.
    load_word(8'hFF, 8'hFF, 8'hFF, 1'b0);
    din = 8'h00; exp_m = 8'h00; exp_l = 8'h00; exp_par = 1'b0; load_valid = 1'b1;
    run = 0; lasts = 0; done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (m_val) begin
        run++;
        if (m_last) lasts++;
      end else done = 1'b1;
      if (load_valid && m_lr) begin
        @(posedge clk);
        #1;
        load_valid = 1'b0;
      end
    end
    chk("b2b contiguous beats", 32'(run), 32'(2 * FRAME));
    chk("b2b s_last pulses", 32'(lasts), 2);
    chk("b2b ended", 32'(done), 1);
    wait_idle();

    // Reset mid-frame after three beats.
    load_word(8'hC3, 8'hC3, 8'hC3, 1'b0);
    cyc(); cyc(); cyc();
    reset = 1'b0;
    #1;
    chk("abort s_valid", 32'(m_val), 0);
    chk("abort load_ready", 32'(m_lr), 1);
    chk("abort busy", 32'(m_busy), 0);
    chk("abort s_out", 32'(m_out), 0);
    chk("abort s_last", 32'(m_last), 0);
    chk("abort lsb s_valid", 32'(l_val), 0);
    cyc();
    reset = 1'b1;
    cyc();
    load_word(8'h81, 8'h81, 8'h81, 1'b0);
    wait_idle();

    // WIDTH=1: one data beat per frame.
    w_din = 1'b1; w_lv = 1'b1;
    @(negedge clk);
    chk("w1 load_ready idle", 32'(w_lr), 1);
    cyc();
    w_lv = 1'b0;
    chk("w1 s_valid", 32'(w_val), 1);
    chk("w1 s_out", 32'(w_out), 1);
    chk("w1 s_last", 32'(w_last), 32'(!PAR));
    chk("w1 busy", 32'(w_busy), 1);
    cyc();
    if (PAR) begin
      chk("w1 parity s_out", 32'(w_out), 1);
      chk("w1 parity s_last", 32'(w_last), 1);
      cyc();
    end
    chk("w1 done s_valid", 32'(w_val), 0);
    chk("w1 done busy", 32'(w_busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
